// File: rtl/core_lbuf_feeder.sv
// core_lbuf_feeder: streams a rows x cols tile from core memory into LBUF under back-pressure (optional perf counters via CORE_LBUF_FEEDER_PERF_EN)
module core_lbuf_feeder #(
  parameter int GBUS_ADDR = 12,
  parameter int CNT_W     = 10,
  parameter int DRAIN_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [GBUS_ADDR-1:0] cfg_base,
  input  logic [CNT_W-1:0]     cfg_cols,
  input  logic [CNT_W-1:0]     cfg_rows,
  input  logic [GBUS_ADDR-1:0] cfg_stride,
  input  logic                 lbuf_almost_full,
  input  logic                 lbuf_full,
  output logic                 cmem_ren,
  output logic [GBUS_ADDR-1:0] cmem_raddr,
  output logic                 busy,
  output logic                 done
`ifdef CORE_LBUF_FEEDER_PERF_EN
  ,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_reads
`endif
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;
  state_t state, nstate;
  logic [GBUS_ADDR-1:0] base_q, stride_q, row_base, cur_base, cur_stride;
  logic [CNT_W-1:0] cols_q, rows_q, col, row, cur_col, cur_row, cur_cols;
  logic [DW-1:0] dcnt;
  logic blk, accept, all_issued, issue, wrap, idle;
  assign blk        = lbuf_almost_full | lbuf_full;
  assign idle       = state == IDLE;
  assign accept     = idle & cfg_start & ~cfg_abort;
  assign all_issued = row == rows_q;
  // The job's first word is issued straight from cfg_* on the accepting edge, so the counters are muxed with the live config in IDLE
  assign cur_base   = idle ? cfg_base : row_base;
  assign cur_stride = idle ? cfg_stride : stride_q;
  assign cur_cols   = idle ? cfg_cols : cols_q;
  assign cur_col    = idle ? '0 : col;
  assign cur_row    = idle ? '0 : row;
  assign wrap       = cur_col == cur_cols - 1'b1;
  assign issue      = ~cfg_abort & ((accept & |cfg_rows & |cfg_cols) | (state == ISSUE & ~blk & ~all_issued));
  // State register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= nstate;
  // Next-state logic; abort overrides everything
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = cfg_start ? ((|cfg_rows & |cfg_cols) ? ISSUE : DONE) : IDLE;
      ISSUE:   nstate = all_issued ? DRAIN : (blk ? WAIT : ISSUE);
      WAIT:    nstate = blk ? WAIT : ISSUE;
      DRAIN:   nstate = dcnt == DW'(DRAIN_CYC - 1) ? DONE : DRAIN;
      default: nstate = IDLE;
    endcase
    if (cfg_abort) nstate = IDLE;
  end
  // Status outputs decoded from state
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  // Registered read channel, shadow config and tile walk counters
  always_ff @(posedge clk)
    if (rst | cfg_abort) begin
      cmem_ren   <= 1'b0;
      cmem_raddr <= '0;
      base_q     <= '0;
      stride_q   <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
      row_base   <= '0;
      col        <= '0;
      row        <= '0;
      dcnt       <= '0;
    end else begin
      cmem_ren <= issue;
      dcnt     <= state == DRAIN ? dcnt + 1'b1 : '0;
      if (accept) begin
        base_q   <= cfg_base;
        stride_q <= cfg_stride;
        cols_q   <= cfg_cols;
        rows_q   <= cfg_rows;
      end
      if (issue) begin
        cmem_raddr <= cur_base + GBUS_ADDR'(cur_col);
        col        <= wrap ? '0 : cur_col + 1'b1;
        row        <= cur_row + CNT_W'(wrap);
        row_base   <= wrap ? cur_base + cur_stride : cur_base;
      end
    end
`ifdef CORE_LBUF_FEEDER_PERF_EN
  logic stall;
  assign stall = state == WAIT | (state == ISSUE & blk & ~all_issued);
  // Saturating stall and read counters, restarted by each accepted job
  always_ff @(posedge clk)
    if (rst | accept) begin
      perf_stall <= '0;
      perf_reads <= '0;
    end else begin
      if (stall & ~&perf_stall)    perf_stall <= perf_stall + 1'b1;
      if (cmem_ren & ~&perf_reads) perf_reads <= perf_reads + 1'b1;
    end
`endif
endmodule

// File: tb/tb_core_lbuf_feeder.sv
// tb_core_lbuf_feeder: scoreboard bench for core_lbuf_feeder
module tb_core_lbuf_feeder;
  logic clk = 0, rst = 1, cfg_start = 0, cfg_abort = 0;
  logic [11:0] cfg_base = 0, cfg_stride = 0;
  logic [9:0] cfg_cols = 0, cfg_rows = 0;
  logic lbuf_almost_full = 0, lbuf_full = 0;
  logic cmem_ren, busy, done;
  logic [11:0] cmem_raddr;
`ifdef CORE_LBUF_FEEDER_PERF_EN
  logic [31:0] perf_stall, perf_reads;
`endif
  int errors = 0, checks = 0;
  int cyc = 0, t0 = 0, nreads = 0, ndone = 0, done_cyc = 0, last_rd = 0, maxgap = 0;
  logic [11:0] q[$];

  core_lbuf_feeder dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_base(cfg_base), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_stride(cfg_stride),
    .lbuf_almost_full(lbuf_almost_full), .lbuf_full(lbuf_full),
    .cmem_ren(cmem_ren), .cmem_raddr(cmem_raddr), .busy(busy), .done(done)
`ifdef CORE_LBUF_FEEDER_PERF_EN
    , .perf_stall(perf_stall), .perf_reads(perf_reads)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [11:0] e;
    @(negedge clk);
    if (cmem_ren) begin
      e = 'x;
      if (q.size() > 0) e = q.pop_front();
      chk("read_addr", {20'h0, cmem_raddr}, {20'h0, e});
      nreads++;
      if (nreads > 1 && cyc - last_rd > maxgap) maxgap = cyc - last_rd;
      last_rd = cyc;
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
    end
  endtask

  task automatic start_job(input logic [11:0] b, input int c, input int r, input logic [11:0] s);
    logic [11:0] a;
    nreads = 0; ndone = 0; maxgap = 0;
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++) begin
        a = b + 12'(i) * s + 12'(j);
        q.push_back(a);
      end
    cfg_base = b; cfg_cols = 10'(c); cfg_rows = 10'(r); cfg_stride = s;
    cfg_start = 1;
    t0 = cyc;
    tick();
    cfg_start = 0;
  endtask

  task automatic wait_reads(input int n);
    for (int i = 0; i < 100 && nreads < n; i++) tick();
    chk("reads_reached", nreads, n);
  endtask

  task automatic wait_done(input int n, input int lat);
    for (int i = 0; i < 200 && ndone == 0; i++) tick();
    chk("done_seen", ndone, 1);
    chk("done_cyc", done_cyc, t0 + lat);
    chk("read_count", nreads, n);
    chk("q_empty", q.size(), 0);
    tick();
    chk("busy_after_done", {31'h0, busy}, 0);
    chk("single_done", ndone, 1);
  endtask

  initial begin
    tick(); tick();
    chk("rst_ren", {31'h0, cmem_ren}, 0);
    chk("rst_raddr", {20'h0, cmem_raddr}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    rst = 0;
    tick();
    // plain job
    start_job(12'h010, 4, 3, 12'h020);
    chk("busy_running", {31'h0, busy}, 1);
    wait_done(12, 12 + 3);
    // same job with almost_full for 5 cycles after the 6th read
    start_job(12'h010, 4, 3, 12'h020);
    wait_reads(6);
    lbuf_almost_full = 1;
    repeat (5) tick();
    lbuf_almost_full = 0;
    wait_done(12, 12 + 6 + 3);
    chk("stall_gap", {31'h0, maxgap >= 6}, 1);
`ifdef CORE_LBUF_FEEDER_PERF_EN
    chk("perf_reads", perf_reads, 12);
    chk("perf_stall_min", {31'h0, perf_stall >= 5}, 1);
`endif
    // lbuf_full for 2 cycles after the first read
    start_job(12'h080, 2, 2, 12'h100);
    lbuf_full = 1;
    repeat (2) tick();
    lbuf_full = 0;
    wait_done(4, 4 + 3 + 3);
    // address wrap across MSB, back-to-back with previous job
    start_job(12'h7FE, 4, 1, 12'h000);
    wait_done(4, 4 + 3);
    // zero-size jobs
    start_job(12'h123, 5, 0, 12'h010);
    wait_done(0, 1);
    start_job(12'h123, 0, 5, 12'h010);
    wait_done(0, 1);
    // abort after 3rd read, then restart the next cycle
    start_job(12'h100, 5, 4, 12'h010);
    wait_reads(3);
    q.delete();
    cfg_abort = 1;
    cfg_start = 1;
    tick();
    cfg_start = 0;
    cfg_abort = 0;
    chk("abort_ren", {31'h0, cmem_ren}, 0);
    chk("abort_busy", {31'h0, busy}, 0);
    chk("abort_no_done", ndone, 0);
    chk("abort_reads", nreads, 3);
    start_job(12'h200, 2, 2, 12'h040);
    wait_done(4, 4 + 3);
    // reset mid-ISSUE
    start_job(12'h040, 4, 3, 12'h020);
    wait_reads(2);
    q.delete();
    rst = 1;
    tick();
    chk("mrst_ren", {31'h0, cmem_ren}, 0);
    chk("mrst_raddr", {20'h0, cmem_raddr}, 0);
    chk("mrst_busy", {31'h0, busy}, 0);
    chk("mrst_done", {31'h0, done}, 0);
    rst = 0;
    tick();
    chk("mrst_idle", {31'h0, busy}, 0);
    chk("mrst_reads", nreads, 2);
    // start while busy and cfg changes mid-job are ignored
    start_job(12'h300, 3, 2, 12'h008);
    cfg_base = 12'h700; cfg_cols = 1; cfg_rows = 1; cfg_stride = 12'h111;
    cfg_start = 1;
    repeat (2) tick();
    cfg_start = 0;
    wait_done(6, 6 + 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
